// File: rtl/if_id_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_id_fetch_stage
//
// This module is the fetch stage of the 5-stage pipeline together with the
// IF/ID pipeline register.
//   - It holds the PC and drives the instruction-memory address directly from
//     the PC register.
//   - It latches the fetched word and its PC+4 into IF/ID.
//   - A taken branch from the ID-stage compare loads branch_target into the PC
//     and squashes the wrong-path fetch. There is no delay slot.
//   - A hazard-unit stall freezes the PC and IF/ID. During a stall the branch
//     decision is ignored, because the compare operands are not ready yet.
//   - Two saturating counters record applied redirects and stalled cycles.
//
// Ports
//   clk            in   pipeline clock; all state updates on the rising edge
//   rst            in   synchronous active-high reset (overrides everything)
//   stall          in   hold PC and IF/ID this cycle
//   pc_src         in   branch taken (from the ID-stage compare)
//   branch_target  in   32-bit redirect address computed in ID
//   imem_rdata     in   32-bit instruction word, a same-cycle read of imem_addr
//   imem_addr      out  current PC (no added latency)
//   if_id_instr    out  registered instruction presented to ID
//   if_id_pc_plus4 out  registered PC+4 of that instruction
//   if_id_valid    out  1 = real instruction, 0 = bubble
//   taken_count    out  saturating count of applied branch redirects
//   stall_count    out  saturating count of stalled cycles
// -----------------------------------------------------------------------------
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 pc_src,
    input  logic [31:0]          branch_target,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          imem_addr,
    output logic [31:0]          if_id_instr,
    output logic [31:0]          if_id_pc_plus4,
    output logic                 if_id_valid,
    output logic [CNT_WIDTH-1:0] taken_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Architectural state (_q) and its next-state values (_d).
    logic [31:0]          pc_q,          pc_d;
    logic [31:0]          instr_q,       instr_d;
    logic [31:0]          pc_plus4_q,    pc_plus4_d;
    logic                 valid_q,       valid_d;
    logic [CNT_WIDTH-1:0] taken_cnt_q,   taken_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q,   stall_cnt_d;

    // Sequential PC increment. The addition is modulo 2^32, so 32'hFFFF_FFFC
    // wraps to 0. The low two bits pass through untouched, since no alignment
    // is enforced.
    logic [31:0] pc_plus4;
    assign pc_plus4 = pc_q + 32'd4;

    // ------------------------------------------------------------------------
    // Next-state logic
    // Priority: stall > taken branch > sequential fetch.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets its hold value first, so that no path through
        // the branches below can leave one unassigned and infer a latch.
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc_plus4_d  = pc_plus4_q;
        valid_d     = valid_q;
        taken_cnt_d = taken_cnt_q;
        stall_cnt_d = stall_cnt_q;

        if (stall) begin
            // Freeze everything. pc_src is deliberately not looked at here,
            // because the compare result is invalid while operands are pending.
            if (stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
        end else if (pc_src) begin
            // Redirect and drop the wrong-path word that is being fetched this
            // cycle.
            pc_d       = branch_target;
            instr_d    = NOP_INSTR;
            pc_plus4_d = 32'h0;
            valid_d    = 1'b0;
            if (taken_cnt_q != CNT_MAX) begin
                taken_cnt_d = taken_cnt_q + CNT_ONE;
            end
        end else begin
            pc_d       = pc_plus4;
            instr_d    = imem_rdata;
            pc_plus4_d = pc_plus4;
            valid_d    = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // State registers (synchronous reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading the
        // pre-edge values, independent of statement order.
        if (rst) begin
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            pc_plus4_q  <= 32'h0;
            valid_q     <= 1'b0;
            taken_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc_plus4_q  <= pc_plus4_d;
            valid_q     <= valid_d;
            taken_cnt_q <= taken_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Every output comes straight from a register. There is no combinational
    // path from stall or pc_src.
    assign imem_addr      = pc_q;
    assign if_id_instr    = instr_q;
    assign if_id_pc_plus4 = pc_plus4_q;
    assign if_id_valid    = valid_q;
    assign taken_count    = taken_cnt_q;
    assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_fetch_stage
//
// Directed bench for if_id_fetch_stage.
//   - Instruction memory model: each word reads as 32'h1000_0000 + address.
//   - A second instance with CNT_WIDTH=4 shares all inputs and is used to
//     exercise counter saturation.
// -----------------------------------------------------------------------------
module tb_if_id_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        pc_src;
    logic [31:0] branch_target;

    // Main instance (16-bit counters)
    logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc_plus4;
    logic        if_id_valid;
    logic [15:0] taken_count, stall_count;

    // Small-counter instance (4-bit counters)
    logic [31:0] s_imem_addr, s_imem_rdata, s_if_id_instr, s_if_id_pc_plus4;
    logic        s_if_id_valid;
    logic [3:0]  s_taken_count, s_stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_rdata   = 32'h1000_0000 + imem_addr;
    assign s_imem_rdata = 32'h1000_0000 + s_imem_addr;

    if_id_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .imem_rdata     (imem_rdata),
        .imem_addr      (imem_addr),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid),
        .taken_count    (taken_count),
        .stall_count    (stall_count)
    );

    if_id_fetch_stage #(.RESET_PC(32'h0), .NOP_INSTR(NOP), .CNT_WIDTH(4)) dut_small (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .imem_rdata     (s_imem_rdata),
        .imem_addr      (s_imem_addr),
        .if_id_instr    (s_if_id_instr),
        .if_id_pc_plus4 (s_if_id_pc_plus4),
        .if_id_valid    (s_if_id_valid),
        .taken_count    (s_taken_count),
        .stall_count    (s_stall_count)
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic        pc_src;
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pcp4;
        logic        exp_valid;
        logic [15:0] exp_taken;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic p, input logic [31:0] t,
                       input logic [31:0] a, input logic [31:0] i, input logic [31:0] p4,
                       input logic v, input logic [15:0] tc, input logic [15:0] sc);
        vec_t x;
        x.rst = r; x.stall = s; x.pc_src = p; x.target = t;
        x.exp_addr = a; x.exp_instr = i; x.exp_pcp4 = p4; x.exp_valid = v;
        x.exp_taken = tc; x.exp_stall = sc;
        vecs.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_target = 32'h0;

        // Expected state after the edge on which the inputs are applied.
        //    rst  stl  src  target        addr          instr         pc+4          v     taken  stall
        add(1'b1, 1'b0, 1'b0, 32'h0,        32'h0,        NOP,          32'h0,        1'b0, 16'd0, 16'd0); // reset
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,       1'b1, 16'd0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h1000_0004, 32'h8,       1'b1, 16'd0, 16'd0);
        add(1'b0, 1'b0, 1'b1, 32'h40,       32'h40,       NOP,          32'h0,        1'b0, 16'd1, 16'd0); // taken at PC=8
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'h1000_0040, 32'h44,      1'b1, 16'd1, 16'd0);
        add(1'b0, 1'b1, 1'b1, 32'h80,       32'h44,       32'h1000_0040, 32'h44,      1'b1, 16'd1, 16'd1); // stall wins
        add(1'b0, 1'b1, 1'b1, 32'h80,       32'h44,       32'h1000_0040, 32'h44,      1'b1, 16'd1, 16'd2);
        add(1'b0, 1'b1, 1'b1, 32'h80,       32'h44,       32'h1000_0040, 32'h44,      1'b1, 16'd1, 16'd3);
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h48,       32'h1000_0044, 32'h48,      1'b1, 16'd1, 16'd3); // resume
        add(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,        32'h0,        1'b0, 16'd2, 16'd3);
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h0FFF_FFFC, 32'h0,       1'b1, 16'd2, 16'd3); // wrap
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,       1'b1, 16'd2, 16'd3);
        add(1'b0, 1'b0, 1'b1, 32'h100,      32'h100,      NOP,          32'h0,        1'b0, 16'd3, 16'd3); // back-to-back
        add(1'b0, 1'b0, 1'b1, 32'h200,      32'h200,      NOP,          32'h0,        1'b0, 16'd4, 16'd3);
        add(1'b0, 1'b1, 1'b1, 32'h300,      32'h200,      NOP,          32'h0,        1'b0, 16'd4, 16'd4);
        add(1'b1, 1'b1, 1'b1, 32'h300,      32'h0,        NOP,          32'h0,        1'b0, 16'd0, 16'd0); // reset wins
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,       1'b1, 16'd0, 16'd0);
        add(1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h1000_0004, 32'h8,       1'b1, 16'd0, 16'd0);

        foreach (vecs[k]) begin
            rst = vecs[k].rst; stall = vecs[k].stall;
            pc_src = vecs[k].pc_src; branch_target = vecs[k].target;
            tick();
            check($sformatf("v%0d imem_addr", k),      imem_addr,           vecs[k].exp_addr);
            check($sformatf("v%0d if_id_instr", k),    if_id_instr,         vecs[k].exp_instr);
            check($sformatf("v%0d if_id_pc_plus4", k), if_id_pc_plus4,      vecs[k].exp_pcp4);
            check($sformatf("v%0d if_id_valid", k),    {31'b0, if_id_valid}, {31'b0, vecs[k].exp_valid});
            check($sformatf("v%0d taken_count", k),    {16'b0, taken_count}, {16'b0, vecs[k].exp_taken});
            check($sformatf("v%0d stall_count", k),    {16'b0, stall_count}, {16'b0, vecs[k].exp_stall});
        end

        // Outputs must not react combinationally to stall or pc_src.
        // PC is 8 here, and IF/ID holds the fetch from 4.
        rst = 1'b0; stall = 1'b1; pc_src = 1'b1; branch_target = 32'h500;
        #1;
        check("comb imem_addr", imem_addr,  32'h8);
        check("comb valid",     {31'b0, if_id_valid}, 32'h1);
        stall = 1'b0; pc_src = 1'b0;

        // Saturation: 20 stalls, then 20 taken branches. The 4-bit counters
        // must stop at 4'hF; the 16-bit counters keep counting.
        for (int i = 0; i < 20; i++) begin
            stall = 1'b1; pc_src = 1'b0;
            tick();
            check($sformatf("sat stall %0d", i), {28'b0, s_stall_count},
                  (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        check("main stall_count 20", {16'b0, stall_count}, 32'd20);
        check("small addr held",     s_imem_addr, 32'h8);

        for (int i = 0; i < 20; i++) begin
            stall = 1'b0; pc_src = 1'b1; branch_target = 32'h1000 + 32'(i * 4);
            tick();
            check($sformatf("sat taken %0d", i), {28'b0, s_taken_count},
                  (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        check("main taken_count 20",   {16'b0, taken_count}, 32'd20);
        check("small stall stays F",   {28'b0, s_stall_count}, 32'd15);
        check("last redirect addr",    imem_addr, 32'h104C);
        check("last redirect valid",   {31'b0, if_id_valid}, 32'h0);

        // One normal fetch after the redirects.
        pc_src = 1'b0;
        tick();
        check("post redirect instr", if_id_instr,    32'h1000_104C);
        check("post redirect pcp4",  if_id_pc_plus4, 32'h1050);
        check("post redirect addr",  imem_addr,      32'h1050);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
